// File: rtl/byte_deframer_pkg.sv
// Shared definitions for the serial receive path: default oversampling
// ratio, frame geometry, line idle level and the deframer state type.
package byte_deframer_pkg;

  // sample_clk cycles per bit; must match the upstream mid-bit sampler.
  localparam int unsigned SAMPLE_RATIO_DEF = 16;

  // Data bits per frame (fixed at 8 in this revision).
  localparam int unsigned DATA_BITS = 8;

  // Serial line level when idle; also the level of a valid stop bit.
  localparam logic LINE_IDLE = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    STOP = 2'd2
  } state_e;

endpackage

// File: rtl/byte_deframer_rx_hold_reg.sv
// rx_hold_reg: single-entry valid/ready holding register for received bytes.
//   clk_i       clock (posedge)
//   rst_i       synchronous active-high reset
//   deliver_i   a good byte is offered this cycle on byte_i
//   byte_i      byte to store on deliver
//   ready_i     consumer accepts data_o this cycle when valid_o=1
//   clr_err_i   clears the sticky overrun flag
//   data_o      held byte, stable while valid_o=1
//   valid_o     register full
//   overrun_o   sticky: a delivered byte was dropped because the register was full
module rx_hold_reg
  import byte_deframer_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 deliver_i,
  input  logic [DATA_BITS-1:0] byte_i,
  input  logic                 ready_i,
  input  logic                 clr_err_i,
  output logic [DATA_BITS-1:0] data_o,
  output logic                 valid_o,
  output logic                 overrun_o
);

  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ovr_q, ovr_d;
  logic                 accept;

  assign accept = valid_q & ready_i;

  // Later assignments take priority: a deliver overrides the accept's
  // clear of valid, and an overrun set overrides clr_err.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    if (accept) valid_d = 1'b0;
    if (clr_err_i) ovr_d = 1'b0;
    if (deliver_i) begin
      if (!valid_q || accept) begin
        data_d  = byte_i;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign data_o    = data_q;
  assign valid_o   = valid_q;
  assign overrun_o = ovr_q;

endmodule

// File: rtl/byte_deframer.sv
// byte_deframer: assembles LSB-first data bits from the mid-bit sampler's
// strobes, times the stop bit itself, and hands good bytes to a holding
// register.
//   sample_clk  oversampling clock (posedge)
//   reset       synchronous active-high reset
//   din         serial line, idle high
//   sample_sig  one-cycle strobe at mid-bit of each data bit
//   data_ready  consumer accepts data_out when data_valid=1
//   clr_err     clears sticky overrun
//   data_out    received byte
//   data_valid  holding register full
//   frame_err   one-cycle pulse: stop bit sampled low
//   overrun     sticky: good byte dropped, holding register was full
//   busy        frame in progress
module byte_deframer
  import byte_deframer_pkg::*;
#(
  parameter int unsigned SAMPLE_RATIO = SAMPLE_RATIO_DEF
) (
  input  logic                 sample_clk,
  input  logic                 reset,
  input  logic                 din,
  input  logic                 sample_sig,
  input  logic                 data_ready,
  input  logic                 clr_err,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam logic [3:0] TMR_LAST  = 4'(SAMPLE_RATIO - 1);
  localparam logic [3:0] LAST_DBIT = 4'(DATA_BITS - 1);

  state_e               state_q;
  logic [DATA_BITS-1:0] shreg_q;
  logic [3:0]           bit_cnt_q;
  logic [3:0]           tmr_q;
  logic                 frame_err_q;
  logic                 stop_sample;
  logic                 deliver;

  // Mid stop bit: SAMPLE_RATIO cycles after the last data strobe.
  assign stop_sample = (state_q == STOP) && (tmr_q == TMR_LAST);
  assign deliver     = stop_sample && (din == LINE_IDLE);

  always_ff @(posedge sample_clk) begin
    if (reset) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      bit_cnt_q   <= '0;
      tmr_q       <= '0;
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (sample_sig) begin
            shreg_q   <= {din, shreg_q[DATA_BITS-1:1]};
            bit_cnt_q <= 4'd1;
            state_q   <= DATA;
          end
        end
        DATA: begin
          if (sample_sig) begin
            shreg_q   <= {din, shreg_q[DATA_BITS-1:1]};
            bit_cnt_q <= bit_cnt_q + 4'd1;
            if (bit_cnt_q == LAST_DBIT) begin
              state_q <= STOP;
              tmr_q   <= '0;
            end
          end
        end
        STOP: begin
          if (stop_sample) begin
            frame_err_q <= (din != LINE_IDLE);
            state_q     <= IDLE;
          end else begin
            tmr_q <= tmr_q + 4'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  rx_hold_reg u_hold (
    .clk_i     (sample_clk),
    .rst_i     (reset),
    .deliver_i (deliver),
    .byte_i    (shreg_q),
    .ready_i   (data_ready),
    .clr_err_i (clr_err),
    .data_o    (data_out),
    .valid_o   (data_valid),
    .overrun_o (overrun)
  );

  assign frame_err = frame_err_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_byte_deframer.sv
module tb_byte_deframer;

  localparam int unsigned R = 16;

  logic       clk = 1'b0;
  logic       reset, din, sample_sig, data_ready, clr_err;
  logic [7:0] data_out;
  logic       data_valid, frame_err, overrun, busy;

  byte_deframer #(.SAMPLE_RATIO(R)) dut (
    .sample_clk (clk),
    .reset      (reset),
    .din        (din),
    .sample_sig (sample_sig),
    .data_ready (data_ready),
    .clr_err    (clr_err),
    .data_out   (data_out),
    .data_valid (data_valid),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef enum logic [1:0] {RDY_LOW, RDY_HIGH, RDY_PULSE, RDY_RAND} rdy_mode_e;

  typedef struct {
    logic [7:0]  data;
    logic        stop;
    rdy_mode_e   mode;
    int unsigned exp_ferr;
    int          exp_vhi;
    logic        exp_valid;
    logic [7:0]  exp_data;
    logic        exp_ovr;
  } vec_t;

  int unsigned total_cnt = 0;
  int unsigned pass_cnt  = 0;

  // Observation of the consumer side, sampled away from the active edge.
  int unsigned cyc = 0;
  int unsigned ferr_cnt = 0;
  int unsigned vhi_cnt = 0;
  int unsigned vrise_cyc = 0;
  int unsigned strobe8_cyc = 0;
  logic        prev_valid = 1'b0;
  logic [7:0]  acc_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (frame_err === 1'b1) ferr_cnt++;
    if (data_valid === 1'b1) vhi_cnt++;
    if (data_valid === 1'b1 && prev_valid !== 1'b1) vrise_cyc = cyc;
    if (data_valid === 1'b1 && data_ready === 1'b1) acc_q.push_back(data_out);
    prev_valid = data_valid;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int unsigned n);
    din = 1'b1;
    sample_sig = 1'b0;
    repeat (n) tick();
  endtask

  // Emulates line plus sampler: start bit, 8 data bits, stop bit, each R
  // cycles long, with a strobe in the middle of each data bit.
  task automatic send_bits(input logic [7:0] b, input logic stop, input rdy_mode_e m,
                           input logic clr_at_stop, input int unsigned periods);
    for (int p = 0; p < int'(periods); p++) begin
      for (int c = 0; c < int'(R); c++) begin
        bit at_stop;
        at_stop = (p == 9) && (c == int'(R / 2));
        if (p == 0) din = 1'b0;
        else if (p == 9) din = stop;
        else din = b[p-1];
        sample_sig = (p >= 1) && (p <= 8) && (c == int'(R / 2));
        case (m)
          RDY_LOW:   data_ready = 1'b0;
          RDY_HIGH:  data_ready = 1'b1;
          RDY_PULSE: data_ready = at_stop;
          default:   data_ready = 1'($urandom_range(0, 1));
        endcase
        clr_err = clr_at_stop && at_stop;
        if (p == 8 && c == int'(R / 2)) strobe8_cyc = cyc;
        tick();
      end
    end
    din = 1'b1;
    sample_sig = 1'b0;
    clr_err = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input rdy_mode_e m);
    send_bits(b, stop, m, 1'b0, 10);
  endtask

  initial begin
    vec_t        vecs[5];
    int unsigned f0, v0, nbad;
    logic [7:0]  exp_q[$];
    logic [7:0]  b;
    logic        s;

    reset = 1'b1; din = 1'b1; sample_sig = 1'b0; data_ready = 1'b0; clr_err = 1'b0;
    repeat (3) tick();
    check("rst_data_out", 32'(data_out), 32'h0);
    check("rst_valid", 32'(data_valid), 32'h0);
    check("rst_frame_err", 32'(frame_err), 32'h0);
    check("rst_overrun", 32'(overrun), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    reset = 1'b0;
    tick();

    // data, stop, ready mode, frame_err pulses, valid-high cycles (-1 skip),
    // then data_valid / data_out / overrun a few cycles after the frame.
    vecs[0] = '{8'hA5, 1'b1, RDY_HIGH, 0,  1, 1'b0, 8'hA5, 1'b0};
    vecs[1] = '{8'h81, 1'b0, RDY_HIGH, 1,  0, 1'b0, 8'hA5, 1'b0};
    vecs[2] = '{8'h42, 1'b1, RDY_HIGH, 0,  1, 1'b0, 8'h42, 1'b0};
    vecs[3] = '{8'h3C, 1'b1, RDY_LOW,  0, -1, 1'b1, 8'h3C, 1'b0};
    vecs[4] = '{8'hC3, 1'b1, RDY_LOW,  0, -1, 1'b1, 8'h3C, 1'b1};

    for (int i = 0; i < 5; i++) begin
      f0 = ferr_cnt;
      v0 = vhi_cnt;
      send_frame(vecs[i].data, vecs[i].stop, vecs[i].mode);
      idle(4);
      check($sformatf("vec%0d_ferr", i), ferr_cnt - f0, vecs[i].exp_ferr);
      if (vecs[i].exp_vhi >= 0)
        check($sformatf("vec%0d_vhi", i), vhi_cnt - v0, 32'(vecs[i].exp_vhi));
      if (vecs[i].exp_vhi == 1)
        check($sformatf("vec%0d_latency", i), vrise_cyc - strobe8_cyc, R + 1);
      check($sformatf("vec%0d_valid", i), 32'(data_valid), 32'(vecs[i].exp_valid));
      check($sformatf("vec%0d_data", i), 32'(data_out), 32'(vecs[i].exp_data));
      check($sformatf("vec%0d_ovr", i), 32'(overrun), 32'(vecs[i].exp_ovr));
      check($sformatf("vec%0d_busy", i), 32'(busy), 32'h0);
    end

    // clr_err clears the sticky overrun, held byte untouched
    clr_err = 1'b1; tick(); clr_err = 1'b0; tick();
    check("clr_ovr", 32'(overrun), 32'h0);
    check("clr_valid", 32'(data_valid), 32'h1);
    check("clr_data", 32'(data_out), 32'h3C);

    // deliver coinciding with an accept: register refilled, valid never drops
    acc_q.delete();
    v0 = vhi_cnt;
    send_frame(8'hC3, 1'b1, RDY_PULSE);
    idle(2);
    check("coinc_data", 32'(data_out), 32'hC3);
    check("coinc_valid", 32'(data_valid), 32'h1);
    check("coinc_ovr", 32'(overrun), 32'h0);
    check("coinc_vhi", vhi_cnt - v0, 10 * R + 2);
    check("coinc_acc_n", acc_q.size(), 1);
    check("coinc_acc0", 32'(acc_q.size() > 0 ? acc_q[0] : 8'hxx), 32'h3C);
    data_ready = 1'b1; tick(); data_ready = 1'b0; tick();
    check("drain_valid", 32'(data_valid), 32'h0);

    // overrun set and clr_err in the same cycle: set wins
    send_frame(8'h11, 1'b1, RDY_LOW);
    send_bits(8'h22, 1'b1, RDY_LOW, 1'b1, 10);
    idle(2);
    check("setwins_ovr", 32'(overrun), 32'h1);
    check("setwins_data", 32'(data_out), 32'h11);
    clr_err = 1'b1; data_ready = 1'b1; tick(); clr_err = 1'b0; data_ready = 1'b0; tick();
    check("setwins_clr", 32'(overrun), 32'h0);

    // reset after 4 strobes discards the partial byte
    send_bits(8'hFF, 1'b1, RDY_HIGH, 1'b0, 5);
    check("partial_busy", 32'(busy), 32'h1);
    reset = 1'b1; tick(); reset = 1'b0;
    check("mid_rst_busy", 32'(busy), 32'h0);
    check("mid_rst_data", 32'(data_out), 32'h0);
    check("mid_rst_valid", 32'(data_valid), 32'h0);
    check("mid_rst_ovr", 32'(overrun), 32'h0);
    check("mid_rst_ferr", 32'(frame_err), 32'h0);
    idle(2 * R);
    acc_q.delete();
    send_frame(8'h5A, 1'b1, RDY_HIGH);
    idle(4);
    check("after_rst_data", 32'(data_out), 32'h5A);
    check("after_rst_acc", 32'(acc_q.size() > 0 ? acc_q[0] : 8'hxx), 32'h5A);

    // ten back-to-back frames
    acc_q.delete();
    f0 = ferr_cnt;
    for (int k = 0; k < 10; k++) send_frame(8'(k), 1'b1, RDY_HIGH);
    idle(4);
    check("b2b_n", acc_q.size(), 10);
    for (int k = 0; k < 10; k++)
      check($sformatf("b2b_%0d", k), 32'(k < acc_q.size() ? acc_q[k] : 8'hxx), 32'(k));
    check("b2b_ferr", ferr_cnt - f0, 0);
    check("b2b_ovr", 32'(overrun), 32'h0);

    // random frames, random consumer: every good byte arrives in order,
    // every bad stop bit gives exactly one frame_err pulse
    acc_q.delete();
    exp_q.delete();
    f0 = ferr_cnt;
    nbad = 0;
    for (int k = 0; k < 40; k++) begin
      b = 8'($urandom);
      s = ($urandom_range(0, 3) != 0);
      if (s) exp_q.push_back(b);
      else nbad++;
      send_frame(b, s, RDY_RAND);
      idle($urandom_range(0, R));
    end
    data_ready = 1'b1;
    idle(4);
    data_ready = 1'b0;
    check("rand_n", acc_q.size(), exp_q.size());
    for (int k = 0; k < exp_q.size(); k++)
      check($sformatf("rand_%0d", k), 32'(k < acc_q.size() ? acc_q[k] : 8'hxx), 32'(exp_q[k]));
    check("rand_ferr", ferr_cnt - f0, nbad);
    check("rand_ovr", 32'(overrun), 32'h0);
    check("rand_busy", 32'(busy), 32'h0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
